// File: rtl/rv32i_fetch_unit.sv
// rv32i_fetch_unit
// Instruction-fetch stage of the RV32I core. Owns the program counter,
// addresses the instruction ROM with the full byte PC, and registers the
// returned word into the IF/ID pipeline register for the decoder.
// Supports stalls, taken-branch/jump redirects with a one-slot flush, and a
// sticky halt when a redirect target is not word aligned.

module rv32i_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,  // must be 4-byte aligned
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013   // addi x0,x0,0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic [31:0] INSTR,
    output logic [31:0] PC,
    output logic [31:0] ID_PC,
    output logic [31:0] ID_PC_PLUS4,
    output logic [31:0] ID_INSTR,
    output logic        ID_VALID,
    output logic        TRAP,
    output logic [31:0] TRAP_ADDR,
    output logic [31:0] FETCH_COUNT
);

    localparam logic [0:0] RUN  = 1'b0;
    localparam logic [0:0] HALT = 1'b1;

    logic [0:0]  state;
    logic [31:0] pc_plus4;
    logic        target_misaligned;

    // Sequential PC increment; wraps modulo 2^32 by construction.
    assign pc_plus4          = PC + 32'd4;
    assign target_misaligned = (BRANCH_TARGET[1:0] != 2'b00);

    // PC, IF/ID register, trap capture and delivered-instruction counter.
    // NOTE: every register here uses non-blocking assignment so that all of
    // them sample the pre-edge values of PC and each other on the same edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= RUN;
            PC          <= RESET_PC;
            ID_PC       <= 32'h0000_0000;
            ID_PC_PLUS4 <= 32'h0000_0004;
            ID_INSTR    <= NOP_INSTR;
            ID_VALID    <= 1'b0;
            TRAP        <= 1'b0;
            TRAP_ADDR   <= 32'h0000_0000;
            FETCH_COUNT <= 32'h0000_0000;
        end else begin
            case (state)
                RUN: begin
                    if (BRANCH_TAKEN && target_misaligned) begin
                        // Misaligned redirect: freeze fetch, record the target.
                        TRAP      <= 1'b1;
                        TRAP_ADDR <= BRANCH_TARGET;
                        ID_VALID  <= 1'b0;
                        ID_INSTR  <= NOP_INSTR;
                        state     <= HALT;
                    end else if (BRANCH_TAKEN) begin
                        // Redirect wins over a stall; the word fetched this
                        // cycle is on the wrong path and is dropped.
                        PC       <= BRANCH_TARGET;
                        ID_VALID <= 1'b0;
                        ID_INSTR <= NOP_INSTR;
                    end else if (!STALL) begin
                        ID_PC       <= PC;
                        ID_PC_PLUS4 <= pc_plus4;
                        ID_INSTR    <= INSTR;
                        ID_VALID    <= 1'b1;
                        PC          <= pc_plus4;
                        FETCH_COUNT <= FETCH_COUNT + 32'd1;
                    end
                    // STALL without redirect: everything holds.
                end
                HALT: begin
                    // Only reset leaves HALT; keep the slot invalid.
                    ID_VALID <= 1'b0;
                    ID_INSTR <= NOP_INSTR;
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Self-checking bench for rv32i_fetch_unit: a table of stimulus/expected
// records fed through a scoreboard queue, plus hand-written sequences for
// the halt, asynchronous reset and PC wrap-around corner cases.

module tb_rv32i_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic        stall;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] pc;
        logic [31:0] id_pc;
        logic [31:0] id_instr;
        logic        valid;
        logic [31:0] cnt;
        logic        trap;
        logic [31:0] trap_addr;
    } vec_t;

    logic        clock;
    logic        reset;
    logic        stall;
    logic        br;
    logic [31:0] tgt;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] id_instr;
    logic        id_valid;
    logic        trap;
    logic [31:0] trap_addr;
    logic [31:0] fetch_count;

    // Second instance exercising the PC wrap at the top of the address space.
    logic        stall2;
    logic        br2;
    logic [31:0] tgt2;
    logic [31:0] instr2;
    logic [31:0] pc2;
    logic [31:0] id_pc2;
    logic [31:0] id_pc_plus4_2;
    logic [31:0] id_instr2;
    logic        id_valid2;
    logic        trap2;
    logic [31:0] trap_addr2;
    logic [31:0] fetch_count2;

    logic [31:0] rom [32];
    vec_t        vecs [14];
    vec_t        sb_q [$];
    int          n_checks;
    int          n_fail;

    rv32i_fetch_unit dut (
        .clock         (clock),
        .reset         (reset),
        .STALL         (stall),
        .BRANCH_TAKEN  (br),
        .BRANCH_TARGET (tgt),
        .INSTR         (instr),
        .PC            (pc),
        .ID_PC         (id_pc),
        .ID_PC_PLUS4   (id_pc_plus4),
        .ID_INSTR      (id_instr),
        .ID_VALID      (id_valid),
        .TRAP          (trap),
        .TRAP_ADDR     (trap_addr),
        .FETCH_COUNT   (fetch_count)
    );

    rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock         (clock),
        .reset         (reset),
        .STALL         (stall2),
        .BRANCH_TAKEN  (br2),
        .BRANCH_TARGET (tgt2),
        .INSTR         (instr2),
        .PC            (pc2),
        .ID_PC         (id_pc2),
        .ID_PC_PLUS4   (id_pc_plus4_2),
        .ID_INSTR      (id_instr2),
        .ID_VALID      (id_valid2),
        .TRAP          (trap2),
        .TRAP_ADDR     (trap_addr2),
        .FETCH_COUNT   (fetch_count2)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ROM model: reads on the falling edge, decodes PC[6:2] only.
    always @(negedge clock) begin
        instr  = rom[pc[6:2]];
        instr2 = rom[pc2[6:2]];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_reset_values();
        check("rst_pc",        pc,                  32'h0);
        check("rst_id_pc",     id_pc,               32'h0);
        check("rst_id_pc4",    id_pc_plus4,         32'h4);
        check("rst_id_instr",  id_instr,            NOP);
        check("rst_id_valid",  {31'b0, id_valid},   32'h0);
        check("rst_trap",      {31'b0, trap},       32'h0);
        check("rst_trap_addr", trap_addr,           32'h0);
        check("rst_count",     fetch_count,         32'h0);
    endtask

    function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                                input logic [31:0] epc, input logic [31:0] eid,
                                input logic [31:0] ein, input logic ev,
                                input logic [31:0] ec, input logic etr,
                                input logic [31:0] eta);
        vec_t v;
        v.stall = s;   v.br = b;     v.tgt = t;
        v.pc = epc;    v.id_pc = eid; v.id_instr = ein; v.valid = ev;
        v.cnt = ec;    v.trap = etr; v.trap_addr = eta;
        return v;
    endfunction

    initial begin
        vec_t e;
        n_checks = 0;
        n_fail   = 0;

        for (int i = 0; i < 32; i++) rom[i] = 32'h13 | (32'(i) << 20);
        rom[0] = 32'h0000_0093;
        rom[1] = 32'h0010_0113;

        //            stl br tgt          pc          id_pc       id_instr  v cnt tr taddr
        vecs[0]  = mk(0, 0, 32'h0,  32'h04, 32'h00, rom[0],  1, 1, 0, 32'h0);
        vecs[1]  = mk(0, 0, 32'h0,  32'h08, 32'h04, rom[1],  1, 2, 0, 32'h0);
        vecs[2]  = mk(1, 0, 32'h0,  32'h08, 32'h04, rom[1],  1, 2, 0, 32'h0);
        vecs[3]  = mk(1, 0, 32'h0,  32'h08, 32'h04, rom[1],  1, 2, 0, 32'h0);
        vecs[4]  = mk(1, 0, 32'h0,  32'h08, 32'h04, rom[1],  1, 2, 0, 32'h0);
        vecs[5]  = mk(0, 0, 32'h0,  32'h0C, 32'h08, rom[2],  1, 3, 0, 32'h0);
        vecs[6]  = mk(0, 0, 32'h0,  32'h10, 32'h0C, rom[3],  1, 4, 0, 32'h0);
        vecs[7]  = mk(1, 1, 32'h40, 32'h40, 32'h0C, NOP,     0, 4, 0, 32'h0);
        vecs[8]  = mk(0, 0, 32'h0,  32'h44, 32'h40, rom[16], 1, 5, 0, 32'h0);
        vecs[9]  = mk(0, 0, 32'h0,  32'h48, 32'h44, rom[17], 1, 6, 0, 32'h0);
        vecs[10] = mk(0, 1, 32'h7C, 32'h7C, 32'h44, NOP,     0, 6, 0, 32'h0);
        vecs[11] = mk(0, 0, 32'h0,  32'h80, 32'h7C, rom[31], 1, 7, 0, 32'h0);
        vecs[12] = mk(0, 0, 32'h0,  32'h84, 32'h80, rom[0],  1, 8, 0, 32'h0);
        vecs[13] = mk(0, 1, 32'h22, 32'h84, 32'h80, NOP,     0, 8, 1, 32'h22);

        reset  = 1'b1;
        stall  = 1'b0; br  = 1'b0; tgt  = 32'h0;
        stall2 = 1'b0; br2 = 1'b0; tgt2 = 32'h0;

        repeat (2) @(posedge clock);
        #1;
        check_reset_values();
        #2 reset = 1'b0;

        // Table: drive, push expectation, clock, pop and compare.
        for (int i = 0; i < 14; i++) begin
            @(negedge clock);
            stall = vecs[i].stall;
            br    = vecs[i].br;
            tgt   = vecs[i].tgt;
            sb_q.push_back(vecs[i]);
            @(posedge clock);
            #1;
            e = sb_q.pop_front();
            check($sformatf("v%0d_pc", i),        pc,                 e.pc);
            check($sformatf("v%0d_id_pc", i),     id_pc,              e.id_pc);
            check($sformatf("v%0d_id_pc4", i),    id_pc_plus4,        e.id_pc + 32'd4);
            check($sformatf("v%0d_id_instr", i),  id_instr,           e.id_instr);
            check($sformatf("v%0d_valid", i),     {31'b0, id_valid},  {31'b0, e.valid});
            check($sformatf("v%0d_count", i),     fetch_count,        e.cnt);
            check($sformatf("v%0d_trap", i),      {31'b0, trap},      {31'b0, e.trap});
            check($sformatf("v%0d_trap_addr", i), trap_addr,          e.trap_addr);
        end

        // HALT: further redirects and stalls must be ignored for 10 edges.
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            br    = 1'b1;
            tgt   = 32'h100 + (32'(i) << 2);
            stall = 1'($urandom_range(0, 1));
            @(posedge clock);
            #1;
            check($sformatf("halt%0d_pc", i),        pc,                32'h84);
            check($sformatf("halt%0d_trap", i),      {31'b0, trap},     32'h1);
            check($sformatf("halt%0d_trap_addr", i), trap_addr,         32'h22);
            check($sformatf("halt%0d_valid", i),     {31'b0, id_valid}, 32'h0);
            check($sformatf("halt%0d_count", i),     fetch_count,       32'h8);
        end

        // Asynchronous reset between edges while halted.
        br = 1'b0; stall = 1'b0; tgt = 32'h0;
        #2 reset = 1'b1;
        #1;
        check_reset_values();
        #2 reset = 1'b0;

        // First edge after reset: both instances deliver their reset-PC word.
        @(posedge clock);
        #1;
        check("post_rst_id_pc",    id_pc,             32'h0);
        check("post_rst_id_instr", id_instr,          rom[0]);
        check("post_rst_valid",    {31'b0, id_valid}, 32'h1);
        check("wrap_e1_pc",        pc2,               32'h0);
        check("wrap_e1_id_pc",     id_pc2,            32'hFFFF_FFFC);
        check("wrap_e1_id_pc4",    id_pc_plus4_2,     32'h0);
        check("wrap_e1_id_instr",  id_instr2,         rom[31]);
        @(posedge clock);
        #1;
        check("wrap_e2_pc",        pc2,               32'h4);
        check("wrap_e2_id_pc",     id_pc2,            32'h0);
        check("wrap_e2_id_instr",  id_instr2,         rom[0]);
        check("wrap_e2_count",     fetch_count2,      32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
